// File: rtl/fxp_op_sched.sv
`default_nettype none
// ============================================================================
// Module      : fxp_op_sched
// Description : Request sequencer for the shared qadd/qmult/qdiv units.
//               Holds one operation in flight and returns a tagged result.
// Revision    : 1.0 - initial release
// ============================================================================
module fxp_op_sched #(
    parameter int WIDTH       = 32,
    parameter int TAG_W       = 4,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_opcode,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] add_c,
    input  logic [WIDTH-1:0] mul_c,
    output logic             div_start,
    input  logic [WIDTH-1:0] div_q,
    input  logic             div_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err
);

    localparam int CNT_W = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);
    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_MUL = 2'b01;
    localparam logic [1:0] c_OP_DIV = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_EXEC      = 3'd1,
        S_DIV_START = 3'd2,
        S_DIV_WAIT  = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    state_t           r_state;
    logic             r_req_ready;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [TAG_W-1:0] r_tag;
    logic [1:0]       r_opcode;
    logic [CNT_W-1:0] r_cnt;
    logic             r_div_start;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic [TAG_W-1:0] r_rsp_tag;
    logic             r_rsp_err;

    logic w_accept;
    assign w_accept = req_valid & r_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_tag       <= '0;
            r_opcode    <= '0;
            r_cnt       <= '0;
            r_div_start <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_tag   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_div_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_op_a      <= req_a;
                        r_op_b      <= req_b;
                        r_tag       <= req_tag;
                        r_opcode    <= req_opcode;
                        // A zero divisor is resolved in EXEC so qdiv never sees it.
                        if (req_opcode == c_OP_DIV && req_b != '0) begin
                            r_state     <= S_DIV_START;
                            r_div_start <= 1'b1;
                        end else begin
                            r_state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_tag   <= r_tag;
                    r_state     <= S_RESP;
                    case (r_opcode)
                        c_OP_ADD: begin
                            r_rsp_data <= add_c;
                            r_rsp_err  <= 1'b0;
                        end
                        c_OP_MUL: begin
                            r_rsp_data <= mul_c;
                            r_rsp_err  <= 1'b0;
                        end
                        default: begin
                            r_rsp_data <= '0;
                            r_rsp_err  <= 1'b1;
                        end
                    endcase
                end
                S_DIV_START: begin
                    r_cnt   <= '0;
                    r_state <= S_DIV_WAIT;
                end
                S_DIV_WAIT: begin
                    // Completion takes priority over a timeout on the same edge.
                    if (div_done) begin
                        r_rsp_data  <= div_q;
                        r_rsp_err   <= 1'b0;
                        r_rsp_tag   <= r_tag;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_tag   <= r_tag;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign div_start = r_div_start;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_tag   = r_rsp_tag;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire
